// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Frame-level controller sitting behind a UART byte receiver. Incoming bytes
// are parsed as HEADER, LEN, LEN payload bytes, CSUM, where
// CSUM = (LEN + sum of payload) mod 256. A validated payload is held in a
// 16-entry buffer and offered to the host with a level-valid/acknowledge
// handshake. Bad lengths, bad checksums, stalled frames and bytes that arrive
// while a frame is held are reported with one-cycle error pulses.
//
// Optional feature macro: UART_FRAME_TIMEOUT_EN
//   defined   : 24-bit inter-byte timeout counter and timeout_err pulse
//   undefined : no counter, timeout_err tied low, stalled frames wait forever
//
// Ports
//   rx_clk        in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   uart_rx_done  in   one-cycle byte-valid strobe
//   uart_rx_data  in   received byte (valid with uart_rx_done)
//   frame_ack     in   host releases the held frame (ignored outside HOLD)
//   rd_addr       in   payload buffer read address
//   rd_data       out  registered buffer read data, one cycle latency
//   frame_valid   out  level, a validated frame is held
//   frame_len     out  payload length of the held frame
//   crc_err       out  pulse, checksum mismatch
//   len_err       out  pulse, length byte 0 or above MAX_LEN
//   timeout_err   out  pulse, inter-byte timeout
//   overrun       out  pulse, byte arrived while a frame was held
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned UART_BPS      = 115200,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       rx_clk,
    input  logic       rst,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_rx_data,
    input  logic       frame_ack,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_valid,
    output logic [4:0] frame_len,
    output logic       crc_err,
    output logic       len_err,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int unsigned TIMEOUT_CYC = TIMEOUT_BYTES * 32'd10 * (CLK_FREQ / UART_BPS);
    localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);

    // Reject configurations the buffer or the 24-bit counter cannot honour.
    if ((MAX_LEN < 32'd1) || (MAX_LEN > 32'd16) ||
        (TIMEOUT_CYC < 32'd2) || (TIMEOUT_CYC > 32'd16777215)) begin : g_bad_cfg
        $error("uart_rx_frame_ctrl: illegal MAX_LEN or timeout configuration");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        mem_we_s;
    logic [7:0]  mem_q [16];

    logic        frame_valid_q, frame_valid_d;
    logic [4:0]  frame_len_q, frame_len_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rd_data_q;

    logic        len_bad_s;
    logic        csum_ok_s;
    logic        tmo_s;

    assign len_bad_s = (uart_rx_data == 8'd0) || (uart_rx_data > MAX_LEN_B);
    assign csum_ok_s = (uart_rx_data == sum_q);

`ifdef UART_FRAME_TIMEOUT_EN
    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYC - 32'd1);

    logic [23:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_run_s;

    assign tmo_run_s = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    // A strobe arriving on the terminal count wins over the timeout.
    assign tmo_s     = tmo_run_s && !uart_rx_done && (tmo_cnt_q == TMO_LAST);

    // Inter-byte counter: cleared by every strobe and outside an open frame.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (uart_rx_done || !tmo_run_s) begin
            tmo_cnt_d = 24'd0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            tmo_cnt_q <= 24'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    // State and frame datapath registers.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= 5'd0;
            idx_q   <= 4'd0;
            sum_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state and datapath update for the framing machine.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        mem_we_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (uart_rx_done && (uart_rx_data == HEADER)) begin
                    state_d = S_LEN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN: begin
                if (uart_rx_done) begin
                    if (len_bad_s) begin
                        state_d = S_IDLE;
                    end else begin
                        len_d   = uart_rx_data[4:0];
                        sum_d   = uart_rx_data;
                        idx_d   = 4'd0;
                        state_d = S_DATA;
                    end
                end else if (tmo_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (uart_rx_done) begin
                    mem_we_s = 1'b1;
                    sum_d    = sum_q + uart_rx_data;
                    idx_d    = idx_q + 4'd1;
                    if ({1'b0, idx_q} == (len_q - 5'd1)) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (tmo_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                if (uart_rx_done) begin
                    if (csum_ok_s) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_HOLD: begin
                if (frame_ack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; the error terms live in disjoint
    // states (timeout only without a strobe), so at most one pulse fires.
    always_comb begin
        frame_valid_d = (state_d == S_HOLD);
        crc_err_d     = (state_q == S_CSUM) && uart_rx_done && !csum_ok_s;
        len_err_d     = (state_q == S_LEN) && uart_rx_done && len_bad_s;
        timeout_err_d = tmo_s;
        overrun_d     = (state_q == S_HOLD) && uart_rx_done;
        if ((state_q == S_CSUM) && uart_rx_done && csum_ok_s) begin
            frame_len_d = len_q;
        end else begin
            frame_len_d = frame_len_q;
        end
    end

    // Output registers.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            frame_valid_q <= 1'b0;
            frame_len_q   <= 5'd0;
            crc_err_q     <= 1'b0;
            len_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            frame_valid_q <= frame_valid_d;
            frame_len_q   <= frame_len_d;
            crc_err_q     <= crc_err_d;
            len_err_q     <= len_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Payload buffer write port; contents are deliberately not reset.
    always_ff @(posedge rx_clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= uart_rx_data;
        end
    end

    // Registered read port, active in every state.
    always_ff @(posedge rx_clk) begin
        if (rst) begin
            rd_data_q <= 8'd0;
        end else begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign crc_err     = crc_err_q;
    assign len_err     = len_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    localparam int TMO = 17360;

    localparam int EV_FRAME = 1;
    localparam int EV_CRC   = 2;
    localparam int EV_LEN   = 3;
    localparam int EV_TO    = 4;
    localparam int EV_OVR   = 5;

    logic       rx_clk = 1'b0;
    logic       rst;
    logic       uart_rx_done;
    logic [7:0] uart_rx_data;
    logic       frame_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic       crc_err;
    logic       len_err;
    logic       timeout_err;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_ev_cyc = 0;
    logic fv_prev = 1'b0;

    int exp_kind_q[$];
    int exp_len_q[$];

    uart_rx_frame_ctrl dut (
        .rx_clk      (rx_clk),
        .rst         (rst),
        .uart_rx_done(uart_rx_done),
        .uart_rx_data(uart_rx_data),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .crc_err     (crc_err),
        .len_err     (len_err),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic expect_ev(input int kind, input int len);
        exp_kind_q.push_back(kind);
        exp_len_q.push_back(len);
    endtask

    task automatic observe(input int kind, input int len);
        int ek;
        int el;
        n_tests++;
        last_ev_cyc = cyc;
        if (exp_kind_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d len=%0d, required none (cycle %0d)", kind, len, cyc);
        end else begin
            ek = exp_kind_q.pop_front();
            el = exp_len_q.pop_front();
            if (ek !== kind || el !== len) begin
                n_fail++;
                $display("FAIL event_order: got kind=%0d len=%0d, required kind=%0d len=%0d (cycle %0d)",
                         kind, len, ek, el, cyc);
            end
        end
    endtask

    // One clock cycle; outputs are examined 1ns after the edge.
    task automatic tick();
        int n_err;
        @(posedge rx_clk);
        #1;
        cyc++;
        n_err = int'(crc_err) + int'(len_err) + int'(timeout_err) + int'(overrun);
        if (n_err != 0) begin
            n_tests++;
            if (n_err > 1) begin
                n_fail++;
                $display("FAIL pulse_exclusive: got %0d simultaneous pulses, required 1", n_err);
            end
        end
        if (frame_valid && !fv_prev) observe(EV_FRAME, int'(frame_len));
        if (crc_err)     observe(EV_CRC, 0);
        if (len_err)     observe(EV_LEN, 0);
        if (timeout_err) observe(EV_TO, 0);
        if (overrun)     observe(EV_OVR, 0);
        fv_prev = frame_valid;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack);
        uart_rx_done = 1'b1;
        uart_rx_data = b;
        frame_ack    = ack;
        tick();
        uart_rx_done = 1'b0;
        frame_ack    = 1'b0;
    endtask

    // Sends HEADER, len, payload (byte i = pl[8i+:8]), checksum (optionally corrupted).
    task automatic send_frame(input int len, input logic [31:0] pl, input bit bad);
        logic [7:0] s;
        s = 8'(len);
        send_byte(8'hA5, 1'b0);
        send_byte(8'(len), 1'b0);
        for (int i = 0; i < len; i++) begin
            s = s + pl[8*i +: 8];
            send_byte(pl[8*i +: 8], 1'b0);
        end
        if (bad) s = s ^ 8'h03;
        send_byte(s, 1'b0);
    endtask

    task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] e);
        rd_addr = a;
        tick();
        n_tests++;
        if (rd_data !== e) begin
            n_fail++;
            $display("FAIL %s: rd_data[%0d]=%h, required %h", name, a, rd_data, e);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic e);
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, got, e);
        end
    endtask

    task automatic check_drain(input string name);
        n_tests++;
        if (exp_kind_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected events never seen, required 0", name, exp_kind_q.size());
        end
        exp_kind_q.delete();
        exp_len_q.delete();
    endtask

    task automatic release_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_bit("ack_drop", frame_valid, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_bit("rst_valid", frame_valid, 1'b0);
        n_tests++;
        if (frame_len !== 5'd0 || rd_data !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_values: frame_len=%0d rd_data=%h, required 0 and 00", frame_len, rd_data);
        end
        check_bit("rst_pulses", crc_err | len_err | timeout_err | overrun, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_frame();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        expect_ev(EV_FRAME, 3);
        send_frame(3, 32'h00332211, 1'b0);
        check_bit("good_valid", frame_valid, 1'b1);
        n_tests++;
        if (frame_len !== 5'd3) begin
            n_fail++;
            $display("FAIL good_len: frame_len=%0d, required 3", frame_len);
        end
        rd_check("good_rd0", 4'd0, 8'h11);
        rd_check("good_rd1", 4'd1, 8'h22);
        rd_check("good_rd2", 4'd2, 8'h33);
        release_frame();
        check_drain("good");
    endtask

    task automatic test_bad_csum();
        expect_ev(EV_CRC, 0);
        send_frame(3, 32'h00332211, 1'b1);
        check_bit("crc_no_valid", frame_valid, 1'b0);
        tick();
        check_drain("crc");
        expect_ev(EV_FRAME, 2);
        send_frame(2, 32'h000055AA, 1'b0);
        rd_check("crc_next_rd0", 4'd0, 8'hAA);
        rd_check("crc_next_rd1", 4'd1, 8'h55);
        release_frame();
        check_drain("crc_next");
    endtask

    task automatic test_len_err();
        expect_ev(EV_LEN, 0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        expect_ev(EV_LEN, 0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h00, 1'b0);
        tick();
        check_bit("len_no_valid", frame_valid, 1'b0);
        check_drain("len");
        expect_ev(EV_FRAME, 1);
        send_frame(1, 32'h0000007E, 1'b0);
        rd_check("len_next_rd0", 4'd0, 8'h7E);
        release_frame();
        check_drain("len_next");
    endtask

    task automatic test_overrun();
        expect_ev(EV_FRAME, 3);
        send_frame(3, 32'h00332211, 1'b0);
        expect_ev(EV_OVR, 0);
        send_byte(8'h55, 1'b0);
        check_bit("ovr_still_valid", frame_valid, 1'b1);
        rd_check("ovr_rd0", 4'd0, 8'h11);
        rd_check("ovr_rd1", 4'd1, 8'h22);
        rd_check("ovr_rd2", 4'd2, 8'h33);
        expect_ev(EV_OVR, 0);
        send_byte(8'h66, 1'b1);
        check_bit("ovr_ack_drop", frame_valid, 1'b0);
        tick();
        tick();
        check_drain("ovr");
    endtask

    task automatic test_timeout();
        int c0;
`ifdef UART_FRAME_TIMEOUT_EN
        expect_ev(EV_TO, 0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        c0 = cyc;
        for (int i = 0; i < TMO + 20; i++) begin
            if (exp_kind_q.size() == 0) break;
            tick();
        end
        n_tests++;
        if (exp_kind_q.size() != 0 || (last_ev_cyc - c0) != TMO) begin
            n_fail++;
            $display("FAIL timeout_latency: pulse %0d cycles after strobe (pending=%0d), required %0d",
                     last_ev_cyc - c0, exp_kind_q.size(), TMO);
        end
        check_drain("timeout");
        expect_ev(EV_FRAME, 1);
        send_frame(1, 32'h0000007E, 1'b0);
        rd_check("timeout_next_rd0", 4'd0, 8'h7E);
        release_frame();
        check_drain("timeout_next");
`else
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        c0 = cyc;
        while (cyc - c0 < TMO + 100) tick();
        check_bit("no_timeout_pulse", timeout_err, 1'b0);
        check_bit("stall_no_valid", frame_valid, 1'b0);
        expect_ev(EV_FRAME, 2);
        send_byte(8'h22, 1'b0);
        send_byte(8'h35, 1'b0);
        check_bit("stall_valid", frame_valid, 1'b1);
        rd_check("stall_rd0", 4'd0, 8'h11);
        rd_check("stall_rd1", 4'd1, 8'h22);
        release_frame();
        check_drain("stall");
`endif
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h11, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("rstmid_valid", frame_valid, 1'b0);
        n_tests++;
        if (frame_len !== 5'd0 || rd_data !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_values: frame_len=%0d rd_data=%h, required 0 and 00", frame_len, rd_data);
        end
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h69, 1'b0);
        tick();
        check_bit("rstmid_lost", frame_valid, 1'b0);
        check_drain("rstmid");
        expect_ev(EV_FRAME, 3);
        send_frame(3, 32'h00332211, 1'b0);
        check_bit("rsthold_pre", frame_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bit("rsthold_valid", frame_valid, 1'b0);
        n_tests++;
        if (frame_len !== 5'd0 || rd_data !== 8'd0) begin
            n_fail++;
            $display("FAIL rsthold_values: frame_len=%0d rd_data=%h, required 0 and 00", frame_len, rd_data);
        end
        tick();
        tick();
        check_drain("rsthold");
    endtask

    initial begin
        rst          = 1'b1;
        uart_rx_done = 1'b0;
        uart_rx_data = 8'h00;
        frame_ack    = 1'b0;
        rd_addr      = 4'd0;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_err();
        test_overrun();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
